// File: rtl/gate_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gate_bist_pkg
//  Purpose  : Shared types and constants for the gate-bank BIST checker:
//             FSM state encoding, gate output bit positions, and the
//             expected truth-table function.
//  Revision : 1.0  initial release
// ============================================================================
package gate_bist_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bit positions of each gate output on the y bus
    localparam int Y_AND  = 0;
    localparam int Y_OR   = 1;
    localparam int Y_XOR  = 2;
    localparam int Y_NAND = 3;
    localparam int Y_NOR  = 4;
    localparam int Y_XNOR = 5;
    localparam int Y_NOT  = 6;

    localparam int NUM_VEC = 4;
    localparam int NUM_OUT = 7;

    // Expected gate-bank response; the inverter is fed from b
    function automatic logic [NUM_OUT-1:0] exp_y(input logic a, input logic b);
        logic [NUM_OUT-1:0] y;
        y         = '0;
        y[Y_AND]  = a & b;
        y[Y_OR]   = a | b;
        y[Y_XOR]  = a ^ b;
        y[Y_NAND] = ~(a & b);
        y[Y_NOR]  = ~(a | b);
        y[Y_XNOR] = ~(a ^ b);
        y[Y_NOT]  = ~b;
        return y;
    endfunction

    // Number of set bits in a gate-output word (0..7)
    function automatic logic [2:0] popcount7(input logic [NUM_OUT-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_bist_ref.sv
`default_nettype none
// ============================================================================
//  Module   : gate_bist_ref
//  Purpose  : Combinational expected-value generator for the gate bank,
//             mapping (a,b) to the seven expected gate outputs.
//  Revision : 1.0  initial release
// ============================================================================
module gate_bist_ref
    import gate_bist_pkg::*;
(
    input  logic               a,
    input  logic               b,
    output logic [NUM_OUT-1:0] exp_val
);

    // Truth-table lookup for the current stimulus vector
    always_comb begin
        exp_val = exp_y(a, b);
    end

endmodule
`default_nettype wire

// File: rtl/gate_bist_checker.sv
`default_nettype none
// ============================================================================
//  Module   : gate_bist_checker
//  Purpose  : Sequential BIST engine for the two-input gate bank. Walks the
//             four (a,b) vectors, holds each for HOLD_CYCLES, samples y_in,
//             and accumulates a saturating mismatch-bit count, per-vector
//             fail flags and a pass flag.
//  Options  : GATE_BIST_LOOP_EN adds a 'loop' input that re-runs the sweep
//             from DONE without clearing the accumulators.
//  Revision : 1.0  initial release
// ============================================================================
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef GATE_BIST_LOOP_EN
    input  logic               loop,
`endif
    output logic               a_o,
    output logic               b_o,
    input  logic [NUM_OUT-1:0] y_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [NUM_VEC-1:0] fail_vec
);

    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t               state;
    logic [1:0]           vec;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [NUM_OUT-1:0]   exp_val;
    logic [NUM_OUT-1:0]   mism;
    logic [2:0]           mism_cnt;
    logic [ERR_W:0]       err_sum;
    logic [ERR_W-1:0]     err_next;
    logic [NUM_VEC-1:0]   fail_next;
    logic                 loop_req;

`ifdef GATE_BIST_LOOP_EN
    assign loop_req = loop;
`else
    assign loop_req = 1'b0;
`endif

    gate_bist_ref u_ref (
        .a       (vec[1]),
        .b       (vec[0]),
        .exp_val (exp_val)
    );

    // Mismatch evaluation and saturating accumulation; only consumed in SAMPLE
    always_comb begin
        mism      = y_in ^ exp_val;
        mism_cnt  = popcount7(mism);
        err_sum   = {1'b0, err_cnt} + (ERR_W+1)'(mism_cnt);
        err_next  = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
        fail_next = fail_vec;
        fail_next[vec] = fail_vec[vec] | (|mism);
    end

    // Control FSM with registered stimulus and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            vec      <= '0;
            hold_cnt <= '0;
            a_o      <= 1'b0;
            b_o      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_APPLY;
                        vec      <= '0;
                        hold_cnt <= '0;
                        {a_o, b_o} <= 2'b00;
                        busy     <= 1'b1;
                        err_cnt  <= '0;
                        fail_vec <= '0;
                    end
                end
                ST_APPLY: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= ST_SAMPLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    err_cnt  <= err_next;
                    fail_vec <= fail_next;
                    if (vec == 2'd3) begin
                        // Stimulus stays at 11 while results are presented
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        vec        <= vec + 2'd1;
                        {a_o, b_o} <= vec + 2'd1;
                        state      <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state    <= ST_APPLY;
                        vec      <= '0;
                        hold_cnt <= '0;
                        {a_o, b_o} <= 2'b00;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_cnt  <= '0;
                        fail_vec <= '0;
                    end else if (loop_req) begin
                        // Re-run keeps the accumulated results sticky
                        state    <= ST_APPLY;
                        vec      <= '0;
                        hold_cnt <= '0;
                        {a_o, b_o} <= 2'b00;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_gate_bist_checker
//  Purpose  : Self-checking bench for gate_bist_checker with a behavioural
//             gate bank, fault injection masks and an expected-result queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gate_bist_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start0, start1;
    logic       a0, b0, busy0, done0, pass0;
    logic       a1, b1, busy1, done1, pass1;
    logic [7:0] err0;
    logic [4:0] err1;
    logic [3:0] fv0, fv1;
    logic [6:0] y0, y1;
    logic [6:0] stuck0, stuck1;
`ifdef GATE_BIST_LOOP_EN
    logic       loop0, loop1;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        int         err;
        logic [3:0] fv;
        logic       pass;
        int         lat;
    } exp_t;

    exp_t sb[$];

    // Healthy gate bank response, bits {not,xnor,nor,nand,xor,or,and}
    function automatic logic [6:0] bank(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 7'b1111000;
            2'b01:   return 7'b0001110;
            2'b10:   return 7'b1001110;
            default: return 7'b0100011;
        endcase
    endfunction

    // Gate bank with stuck-at-0 / stuck-at-1 fault masks
    always_comb y0 = (bank(a0, b0) & ~stuck0) | stuck1;
    always_comb y1 = (bank(a1, b1) & ~stuck0) | stuck1;

    gate_bist_checker #(.HOLD_CYCLES(4), .ERR_W(8)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start0),
`ifdef GATE_BIST_LOOP_EN
        .loop     (loop0),
`endif
        .a_o      (a0),
        .b_o      (b0),
        .y_in     (y0),
        .busy     (busy0),
        .done     (done0),
        .pass     (pass0),
        .err_cnt  (err0),
        .fail_vec (fv0)
    );

    gate_bist_checker #(.HOLD_CYCLES(1), .ERR_W(5)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
`ifdef GATE_BIST_LOOP_EN
        .loop     (loop1),
`endif
        .a_o      (a1),
        .b_o      (b1),
        .y_in     (y1),
        .busy     (busy1),
        .done     (done1),
        .pass     (pass1),
        .err_cnt  (err1),
        .fail_vec (fv1)
    );

    function automatic logic g_done(input int sel); return sel != 0 ? done1 : done0; endfunction
    function automatic logic g_busy(input int sel); return sel != 0 ? busy1 : busy0; endfunction
    function automatic logic g_pass(input int sel); return sel != 0 ? pass1 : pass0; endfunction
    function automatic logic [1:0] g_ab(input int sel); return sel != 0 ? {a1, b1} : {a0, b0}; endfunction
    function automatic int g_err(input int sel); return sel != 0 ? int'(err1) : int'(err0); endfunction
    function automatic logic [3:0] g_fv(input int sel); return sel != 0 ? fv1 : fv0; endfunction

    // Build the expected result for the current fault masks, push it, pulse start
    task automatic launch(input int sel, input int h, input int errw);
        exp_t       e;
        logic [6:0] good, bad;
        e.err = 0;
        e.fv  = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            good  = bank(v[1], v[0]);
            bad   = (good & ~stuck0) | stuck1;
            e.err = e.err + $countones(good ^ bad);
            e.fv[v] = |(good ^ bad);
        end
        if (e.err > (1 << errw) - 1) e.err = (1 << errw) - 1;
        e.pass = (e.err == 0);
        e.lat  = 4 * (h + 1);
        sb.push_back(e);
        if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Follow a run cycle by cycle; k counts negedges after the start edge
    task automatic wait_done(input int sel, input int h, input int repulse_k,
                             output int lat, output bit seq_ok);
        lat    = -1;
        seq_ok = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (g_done(sel) === 1'b1) begin
                lat = k;
                if (g_ab(sel) !== 2'b11 || g_busy(sel) !== 1'b0) seq_ok = 1'b0;
                break;
            end
            if (g_busy(sel) !== 1'b1 || g_ab(sel) !== 2'(k / (h + 1))) seq_ok = 1'b0;
            if (k == repulse_k) begin
                if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
            end
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({a0, b0, busy0, done0, pass0} !== 5'b0 || err0 !== 8'h00 || fv0 !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_dut0: got ab=%b%b busy=%b done=%b pass=%b err=%h fv=%b, want all 0",
                     a0, b0, busy0, done0, pass0, err0, fv0);
        end
        tests_run++;
        if ({a1, b1, busy1, done1, pass1} !== 5'b0 || err1 !== 5'h00 || fv1 !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_dut1: got ab=%b%b busy=%b done=%b pass=%b err=%h fv=%b, want all 0",
                     a1, b1, busy1, done1, pass1, err1, fv1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_wins();
        rst_n  = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        rst_n  = 1'b1;
        start0 = 1'b0;
        tests_run++;
        if (busy0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wins: busy=%b, want 0", busy0);
        end
        @(negedge clk);
        tests_run++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wins_idle: busy=%b done=%b, want 0 0", busy0, done0);
        end
    endtask

    // Run one sweep on dut0 and compare against the queued expectation
    task automatic test_run(input string name, input int repulse_k);
        int   lat;
        bit   seq_ok;
        exp_t e;
        launch(0, 4, 8);
        wait_done(0, 4, repulse_k, lat, seq_ok);
        e = sb.pop_front();
        tests_run++;
        if (lat != e.lat) begin
            tests_failed++;
            $display("FAIL %s_latency: done after %0d cycles, want %0d", name, lat, e.lat);
        end
        tests_run++;
        if (g_err(0) != e.err || fv0 !== e.fv || pass0 !== e.pass) begin
            tests_failed++;
            $display("FAIL %s_result: err=%0d fv=%b pass=%b, want err=%0d fv=%b pass=%b",
                     name, g_err(0), fv0, pass0, e.err, e.fv, e.pass);
        end
        tests_run++;
        if (!seq_ok) begin
            tests_failed++;
            $display("FAIL %s_sequence: stimulus/busy sequence wrong, got 0 want 1", name);
        end
    endtask

    task automatic test_clean();
        stuck0 = 7'h00;
        stuck1 = 7'h00;
        test_run("clean", -1);
        repeat (3) @(negedge clk);
        tests_run++;
        if (done0 !== 1'b1 || pass0 !== 1'b1 || err0 !== 8'h00 || {a0, b0} !== 2'b11) begin
            tests_failed++;
            $display("FAIL clean_hold: done=%b pass=%b err=%h ab=%b%b, want 1 1 00 11",
                     done0, pass0, err0, a0, b0);
        end
    endtask

    task automatic test_stuck_and();
        stuck0 = 7'h01;
        stuck1 = 7'h00;
        test_run("and_sa0", -1);
    endtask

    task automatic test_all_zero();
        stuck0 = 7'h7F;
        stuck1 = 7'h00;
        test_run("all_zero", -1);
    endtask

    // Restart directly from DONE with a different fault; results must be fresh
    task automatic test_back_to_back();
        stuck0 = 7'h00;
        stuck1 = 7'h40;
        test_run("back_to_back", -1);
    endtask

    task automatic test_start_ignored();
        stuck0 = 7'h01;
        stuck1 = 7'h00;
        test_run("start_ignored", 5);
    endtask

    task automatic test_reset_mid_run();
        exp_t dropped;
        stuck0 = 7'h00;
        stuck1 = 7'h00;
        launch(0, 4, 8);
        dropped = sb.pop_back();
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a0, b0, busy0, done0, pass0} !== 5'b0 || err0 !== 8'h00 || fv0 !== 4'h0) begin
            tests_failed++;
            $display("FAIL mid_reset: ab=%b%b busy=%b done=%b pass=%b err=%h fv=%b, want all 0 (dropped err %0d)",
                     a0, b0, busy0, done0, pass0, err0, fv0, dropped.err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        test_run("after_reset", -1);
    endtask

    task automatic test_hold1();
        int   lat;
        bit   seq_ok;
        exp_t e;
        stuck0 = 7'h7F;
        stuck1 = 7'h00;
        launch(1, 1, 5);
        wait_done(1, 1, -1, lat, seq_ok);
        e = sb.pop_front();
        tests_run++;
        if (lat != e.lat || !seq_ok) begin
            tests_failed++;
            $display("FAIL hold1_latency: done after %0d cycles seq_ok=%0d, want %0d and 1", lat, seq_ok, e.lat);
        end
        tests_run++;
        if (g_err(1) != e.err || fv1 !== e.fv || pass1 !== e.pass) begin
            tests_failed++;
            $display("FAIL hold1_result: err=%0d fv=%b pass=%b, want err=%0d fv=%b pass=%b",
                     g_err(1), fv1, pass1, e.err, e.fv, e.pass);
        end
    endtask

`ifdef GATE_BIST_LOOP_EN
    // Three looping passes on dut1 (ERR_W=5): 14, 28, then saturated 31
    task automatic test_loop();
        exp_t e;
        int   prev_err;
        int   seen;
        bit   wrapped;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        stuck0 = 7'h7F;
        stuck1 = 7'h00;
        loop1  = 1'b1;
        launch(1, 1, 5);
        e = sb[0]; e.err = 28; e.lat = 17; sb.push_back(e);
        e.err = 31; e.lat = 26; sb.push_back(e);
        prev_err = 0;
        seen     = 0;
        wrapped  = 1'b0;
        for (int k = 0; k < 200 && seen < 3; k++) begin
            if (g_err(1) < prev_err) wrapped = 1'b1;
            prev_err = g_err(1);
            if (done1 === 1'b1) begin
                e = sb.pop_front();
                seen++;
                if (seen == 3) loop1 = 1'b0;
                tests_run++;
                if (k != e.lat || g_err(1) != e.err || fv1 !== e.fv || pass1 !== e.pass) begin
                    tests_failed++;
                    $display("FAIL loop_pass%0d: k=%0d err=%0d fv=%b pass=%b, want k=%0d err=%0d fv=%b pass=%b",
                             seen, k, g_err(1), fv1, pass1, e.lat, e.err, e.fv, e.pass);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (seen != 3 || done1 !== 1'b1 || err1 !== 5'd31 || wrapped) begin
            tests_failed++;
            $display("FAIL loop_stop: passes=%0d done=%b err=%0d wrapped=%0d, want 3 1 31 0",
                     seen, done1, err1, wrapped);
        end
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        stuck0 = 7'h00;
        stuck1 = 7'h00;
`ifdef GATE_BIST_LOOP_EN
        loop0  = 1'b0;
        loop1  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        test_reset_wins();
        test_clean();
        test_stuck_and();
        test_all_zero();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        test_hold1();
`ifdef GATE_BIST_LOOP_EN
        test_loop();
`endif
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
